pc_fetch_unit: RTL and testbench

- Instruction-fetch stage of the 5-stage pipelined CPU.
- Owns the program counter and drives the instruction-memory address.
- Produces the sequential next PC by instantiating the existing PC+4 adder, accepts stall and redirect (branch/jump) requests from later stages, and registers the fetched instruction into the IF/ID pipeline register.
- It is the consumer side of the PC+4 adder interface: it supplies `pc` and consumes `pc_plus`.

---
 rtl/pc_fetch_unit_pkg.sv | 24 ++
 rtl/pc_fetch_unit_add.sv | 11 +
 rtl/pc_fetch_unit.sv | 82 ++++++++
 tb/tb_pc_fetch_unit.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/pc_fetch_unit_pkg.sv
// Shared CPU definitions used by the fetch stage and the ID stage.
package pc_fetch_unit_pkg;

  // Default boot address and the bubble instruction word.
  localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_3000;
  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0000;

  // Instruction size in bytes; the sequential PC step.
  localparam logic [31:0] WORD_BYTES = 32'd4;

  // IF/ID pipeline register layout consumed by the decode stage.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc_plus;
    logic [31:0] instr;
    logic        valid;
  } if_id_t;

  // Force an address onto a word boundary.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/pc_fetch_unit_add.sv
// PC+4 adder: sequential-address generator, wraps modulo 2^32.
module add
  import pc_fetch_unit_pkg::*;
(
  input  logic [31:0] pc,
  output logic [31:0] pc_plus
);

  assign pc_plus = pc + WORD_BYTES;

endmodule

// File: rtl/pc_fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives imem, fills IF/ID.
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  output logic        imem_en,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_pc_plus,
  output logic [31:0] if_id_instr,
  output logic        if_id_valid,
  output logic        misalign_err
);

  logic [31:0] pc_reg;
  logic [31:0] pc_next;
  logic [31:0] pc_plus;
  if_id_t      if_id_reg;
  if_id_t      if_id_next;
  logic        misalign_reg;
  logic        misalign_next;
  if_id_t      bubble;

  // Sequential next address comes from the shared adder.
  add u_add (
    .pc      (pc_reg),
    .pc_plus (pc_plus)
  );

  // Flushed / reset contents of IF/ID.
  always_comb begin
    bubble         = '0;
    bubble.instr   = NOP_INSTR;
  end

  // Next-PC mux and IF/ID update: redirect beats stall beats advance.
  always_comb begin
    pc_next       = pc_reg;
    if_id_next    = if_id_reg;
    misalign_next = redirect_valid & (redirect_pc[1:0] != 2'b00);
    if (redirect_valid) begin
      pc_next    = word_align(redirect_pc);
      if_id_next = bubble;
    end else if (!stall) begin
      pc_next            = pc_plus;
      if_id_next.pc      = pc_reg;
      if_id_next.pc_plus = pc_plus;
      if_id_next.instr   = imem_rdata;
      if_id_next.valid   = 1'b1;
    end
  end

  // State registers; reset discards in-flight state immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_reg       <= word_align(RESET_PC);
      if_id_reg    <= bubble;
      misalign_reg <= 1'b0;
    end else begin
      pc_reg       <= pc_next;
      if_id_reg    <= if_id_next;
      misalign_reg <= misalign_next;
    end
  end

  assign imem_addr     = pc_reg;
  assign imem_en       = ~stall | redirect_valid;
  assign if_id_pc      = if_id_reg.pc;
  assign if_id_pc_plus = if_id_reg.pc_plus;
  assign if_id_instr   = if_id_reg.instr;
  assign if_id_valid   = if_id_reg.valid;
  assign misalign_err  = misalign_reg;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit; outputs sampled on the falling edge.
module tb_pc_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr;
  logic        imem_en;
  logic [31:0] imem_rdata;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_pc_plus;
  logic [31:0] if_id_instr;
  logic        if_id_valid;
  logic        misalign_err;

  int compared   = 0;
  int mismatched = 0;

  pc_fetch_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_addr      (imem_addr),
    .imem_en        (imem_en),
    .imem_rdata     (imem_rdata),
    .if_id_pc       (if_id_pc),
    .if_id_pc_plus  (if_id_pc_plus),
    .if_id_instr    (if_id_instr),
    .if_id_valid    (if_id_valid),
    .misalign_err   (misalign_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory: two program words, otherwise a tag of the address.
  always_comb begin
    imem_rdata = {16'hA5A5, imem_addr[15:0]};
    if (imem_addr == 32'h0000_3000) imem_rdata = 32'h2401_0005;
    if (imem_addr == 32'h0000_3004) imem_rdata = 32'h2402_0007;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_if_id(input string tag, input logic [31:0] pc, input logic [31:0] pcp,
                             input logic [31:0] instr, input logic valid);
    check({tag, ".pc"}, if_id_pc, pc);
    check({tag, ".pc_plus"}, if_id_pc_plus, pcp);
    check({tag, ".instr"}, if_id_instr, instr);
    check({tag, ".valid"}, {31'd0, if_id_valid}, {31'd0, valid});
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst_n          = 1'b0;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;

    // Reset state
    @(negedge clk);
    check("rst.addr", imem_addr, 32'h0000_3000);
    check_if_id("rst", 32'h0, 32'h0, 32'h0, 1'b0);
    check("rst.misalign", {31'd0, misalign_err}, 32'd0);
    check("rst.en", {31'd0, imem_en}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Sequential fetch
    step();
    check("seq1.addr", imem_addr, 32'h0000_3004);
    check_if_id("seq1", 32'h3000, 32'h3004, 32'h2401_0005, 1'b1);
    step();
    check("seq2.addr", imem_addr, 32'h0000_3008);
    check_if_id("seq2", 32'h3004, 32'h3008, 32'h2402_0007, 1'b1);

    // Stall for two cycles at PC 0x3008
    stall = 1'b1;
    #1 check("stall.en", {31'd0, imem_en}, 32'd0);
    for (int i = 0; i < 2; i++) begin
      step();
      check("stall.addr", imem_addr, 32'h0000_3008);
      check_if_id("stall", 32'h3004, 32'h3008, 32'h2402_0007, 1'b1);
    end
    stall = 1'b0;
    step();
    check("resume.addr", imem_addr, 32'h0000_300C);
    check_if_id("resume", 32'h3008, 32'h300C, 32'hA5A5_3008, 1'b1);

    // Redirect together with stall: redirect wins
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_3040;
    stall          = 1'b1;
    #1 check("redir.en", {31'd0, imem_en}, 32'd1);
    step();
    check("redir.addr", imem_addr, 32'h0000_3040);
    check_if_id("redir", 32'h0, 32'h0, 32'h0, 1'b0);
    check("redir.misalign", {31'd0, misalign_err}, 32'd0);
    redirect_valid = 1'b0;
    stall          = 1'b0;
    step();
    check("redir2.addr", imem_addr, 32'h0000_3044);
    check_if_id("redir2", 32'h3040, 32'h3044, 32'hA5A5_3040, 1'b1);

    // Misaligned redirect
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_3046;
    step();
    check("mis.addr", imem_addr, 32'h0000_3044);
    check("mis.err", {31'd0, misalign_err}, 32'd1);
    check("mis.valid", {31'd0, if_id_valid}, 32'd0);
    redirect_valid = 1'b0;
    step();
    check("mis2.err", {31'd0, misalign_err}, 32'd0);
    check("mis2.addr", imem_addr, 32'h0000_3048);
    check_if_id("mis2", 32'h3044, 32'h3048, 32'hA5A5_3044, 1'b1);

    // Wrap-around
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    step();
    check("wrap.addr", imem_addr, 32'hFFFF_FFFC);
    redirect_valid = 1'b0;
    step();
    check("wrap2.addr", imem_addr, 32'h0000_0000);
    check_if_id("wrap2", 32'hFFFF_FFFC, 32'h0000_0000, 32'hA5A5_FFFC, 1'b1);

    // Back-to-back redirects keep IF/ID a bubble
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_3100;
    step();
    redirect_pc    = 32'h0000_3200;
    step();
    check("b2b.addr", imem_addr, 32'h0000_3200);
    check_if_id("b2b", 32'h0, 32'h0, 32'h0, 1'b0);

    // Reach PC 0x3100 with a valid IF/ID, then reset between edges
    redirect_pc = 32'h0000_30FC;
    step();
    redirect_valid = 1'b0;
    step();
    check("pre.addr", imem_addr, 32'h0000_3100);
    check("pre.valid", {31'd0, if_id_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst.addr", imem_addr, 32'h0000_3000);
    check_if_id("arst", 32'h0, 32'h0, 32'h0, 1'b0);

    // First edge after reset with stall held: nothing captured
    @(negedge clk);
    rst_n = 1'b1;
    stall = 1'b1;
    step();
    check("rstall.addr", imem_addr, 32'h0000_3000);
    check("rstall.valid", {31'd0, if_id_valid}, 32'd0);
    stall = 1'b0;
    step();
    check("rfetch.addr", imem_addr, 32'h0000_3004);
    check_if_id("rfetch", 32'h3000, 32'h3004, 32'h2401_0005, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
